mo_list_reader: RTL and testbench

- Video-side reader of the motion-object (sprite) attribute buffers held in working RAM.
- Once per scanline, walks the active buffer (selected by BUF1BUF2n) two 16-bit words per object.
- Range-checks each object against the next scanline and hands in-range descriptors to the line-buffer painter over a valid/ready handshake.
- Replaces the free-running hcount address with a sequenced fetch that tolerates CPU bus ownership (B2H high).

---
 rtl/mo_pkg.sv | 28 ++
 rtl/mo_range_check.sv | 19 +
 rtl/mo_list_reader.sv | 166 ++++++++++++++++
 tb/tb_mo_list_reader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mo_pkg.sv
// Shared types and constants for the motion-object list reader and its helpers.
// Attribute words sit in RAM as pairs per object: word 0 = {attr, pic}, word 1 = {x, y}.
package mo_pkg;

    localparam int         MO_NUM_OBJ      = 64;
    localparam int         MO_OBJ_HEIGHT   = 16;
    localparam int         MO_MAX_PER_LINE = 16;
    localparam logic [8:0] MO_START_H      = 9'd256;

    // Word offset inside an object's two-word slot.
    localparam logic WORD_YX = 1'b1;
    localparam logic WORD_PA = 1'b0;

    localparam int MO_BYTE_W = 8;
    localparam int MO_IDX_W  = 6;
    localparam int MO_ROW_W  = $clog2(MO_OBJ_HEIGHT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR1,
        ST_READ1,
        ST_ADDR0,
        ST_READ0,
        ST_EMIT,
        ST_DONE
    } mo_state_t;

endpackage

// File: rtl/mo_range_check.sv
// Vertical range test: row inside the object for the target line, with unsigned wrap
// so objects straddling the bottom of the frame reappear at the top.
module mo_range_check #(
    parameter int  OBJ_HEIGHT = 16,
    localparam int ROW_W      = $clog2(OBJ_HEIGHT)
) (
    input  logic [7:0]       i_target,
    input  logic [7:0]       i_y,
    output logic             o_in_range,
    output logic [ROW_W-1:0] o_row
);

    logic [7:0] w_diff;

    assign w_diff     = i_target - i_y;
    assign o_in_range = ({1'b0, w_diff} < 9'(OBJ_HEIGHT));
    assign o_row      = w_diff[ROW_W-1:0];

endmodule

// File: rtl/mo_list_reader.sv
// Per-scanline walker of the motion-object attribute buffer; in-range objects are
// handed to the painter as descriptors over a valid/ready handshake.
module mo_list_reader
    import mo_pkg::*;
#(
    parameter int         NUM_OBJ      = MO_NUM_OBJ,
    parameter int         OBJ_HEIGHT   = MO_OBJ_HEIGHT,
    parameter int         MAX_PER_LINE = MO_MAX_PER_LINE,
    parameter logic [8:0] START_H      = MO_START_H,
    localparam int        ROW_W        = $clog2(OBJ_HEIGHT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [8:0]       hcount,
    input  logic [7:0]       vcount,
    input  logic             BUF1BUF2n,
    input  logic             B2H,
    output logic [7:0]       ram_addr,
    input  logic [7:0]       ram_lo,
    input  logic [7:0]       ram_hi,
    output logic             obj_valid,
    input  logic             obj_ready,
    output logic [7:0]       obj_pic,
    output logic [7:0]       obj_attr,
    output logic [7:0]       obj_x,
    output logic [ROW_W-1:0] obj_row,
    output logic             line_done,
    output logic             overflow,
    output logic             overrun
);

    localparam int                    CNT_W    = $clog2(MAX_PER_LINE + 1);
    localparam logic [MO_IDX_W-1:0]   LAST_IDX = MO_IDX_W'(NUM_OBJ - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(MAX_PER_LINE);

    mo_state_t           r_state;
    mo_state_t           w_next;
    logic                r_buf;
    logic [7:0]          r_target;
    logic [MO_IDX_W-1:0] r_idx;
    logic [CNT_W-1:0]    r_count;
    logic [7:0]          r_pic;
    logic [7:0]          r_attr;
    logic [7:0]          r_x;
    logic [ROW_W-1:0]    r_row;
    logic                r_overflow;
    logic                r_overrun;
    logic [7:0]          r_addr_hold;

    logic                w_start;
    logic                w_abort;
    logic                w_xfer;
    logic                w_last_idx;
    logic [CNT_W-1:0]    w_count_inc;
    logic                w_in_range;
    logic [ROW_W-1:0]    w_row;
    logic                w_advance;

    // Handshake: a descriptor moves on a clk where obj_valid && obj_ready; once raised,
    // obj_valid and the fields hold until that transfer, except on line-start abort or reset.
    assign w_start     = (hcount == START_H);
    assign w_abort     = w_start && (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign w_xfer      = obj_valid && obj_ready;
    assign w_last_idx  = (r_idx == LAST_IDX);
    assign w_count_inc = r_count + CNT_W'(1);
    assign w_advance   = (w_next == ST_ADDR1) && ((r_state == ST_READ1) || (r_state == ST_EMIT));

    mo_range_check #(.OBJ_HEIGHT(OBJ_HEIGHT)) u_range (
        .i_target   (r_target),
        .i_y        (ram_lo),
        .o_in_range (w_in_range),
        .o_row      (w_row)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_buf       <= 1'b0;
            r_target    <= 8'd0;
            r_idx       <= '0;
            r_count     <= '0;
            r_pic       <= 8'd0;
            r_attr      <= 8'd0;
            r_x         <= 8'd0;
            r_row       <= '0;
            r_overflow  <= 1'b0;
            r_overrun   <= 1'b0;
            r_addr_hold <= 8'd0;
        end else begin
            r_state     <= w_next;
            r_addr_hold <= ram_addr;
            if (w_start) begin
                r_buf      <= BUF1BUF2n;
                r_target   <= vcount + 8'd1;
                r_idx      <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
                r_overrun  <= w_abort;
            end else begin
                if (w_advance)
                    r_idx <= r_idx + MO_IDX_W'(1);
                if (w_xfer) begin
                    r_count <= w_count_inc;
                    if (!w_last_idx && (w_count_inc == CNT_MAX))
                        r_overflow <= 1'b1;
                end
            end
            if (r_state == ST_READ1) begin
                r_x   <= ram_hi;
                r_row <= w_row;
            end
            if (r_state == ST_READ0) begin
                r_pic  <= ram_lo;
                r_attr <= ram_hi;
            end
        end
    end

    // Step-to-next-object is folded into READ1 (reject) and EMIT (transfer) so an
    // off-line object costs two clks and an in-range one five.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = ST_IDLE;
            ST_ADDR1: if (!B2H) w_next = ST_READ1;
            ST_READ1: begin
                if (w_in_range)      w_next = ST_ADDR0;
                else if (w_last_idx) w_next = ST_DONE;
                else                 w_next = ST_ADDR1;
            end
            ST_ADDR0: if (!B2H) w_next = ST_READ0;
            ST_READ0: w_next = ST_EMIT;
            ST_EMIT: begin
                if (w_xfer) begin
                    if (w_last_idx || (w_count_inc == CNT_MAX)) w_next = ST_DONE;
                    else                                        w_next = ST_ADDR1;
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (w_start)
            w_next = ST_ADDR1;
    end

    always_comb begin
        ram_addr  = r_addr_hold;
        obj_valid = 1'b0;
        line_done = 1'b0;
        case (r_state)
            ST_ADDR1: ram_addr  = {r_buf, r_idx, WORD_YX};
            ST_ADDR0: ram_addr  = {r_buf, r_idx, WORD_PA};
            ST_EMIT:  obj_valid = !w_start;
            ST_DONE:  line_done = 1'b1;
            default:  ;
        endcase
    end

    assign obj_pic  = r_pic;
    assign obj_attr = r_attr;
    assign obj_x    = r_x;
    assign obj_row  = r_row;
    assign overflow = r_overflow;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_mo_list_reader.sv
// Directed bench for mo_list_reader: RAM model with one-clk read latency, scoreboard of
// expected descriptors, and immediate-assertion checks at each step.
module tb_mo_list_reader;
    import mo_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [8:0] hcount;
    logic [7:0] vcount;
    logic       BUF1BUF2n;
    logic       B2H;
    logic [7:0] ram_addr;
    logic [7:0] ram_lo;
    logic [7:0] ram_hi;
    logic       obj_valid;
    logic       obj_ready;
    logic [7:0] obj_pic;
    logic [7:0] obj_attr;
    logic [7:0] obj_x;
    logic [3:0] obj_row;
    logic       line_done;
    logic       overflow;
    logic       overrun;

    logic [15:0] mem [256];
    logic        b2h_force;
    logic        b2h_toggle;
    logic        tog = 1'b0;

    logic [27:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_xfer = 0;
    int          n_reissue = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_addr = 8'd0;

    mo_list_reader dut (
        .clk       (clk),
        .reset     (reset),
        .hcount    (hcount),
        .vcount    (vcount),
        .BUF1BUF2n (BUF1BUF2n),
        .B2H       (B2H),
        .ram_addr  (ram_addr),
        .ram_lo    (ram_lo),
        .ram_hi    (ram_hi),
        .obj_valid (obj_valid),
        .obj_ready (obj_ready),
        .obj_pic   (obj_pic),
        .obj_attr  (obj_attr),
        .obj_x     (obj_x),
        .obj_row   (obj_row),
        .line_done (line_done),
        .overflow  (overflow),
        .overrun   (overrun)
    );

    // Clock and bus-ownership pattern
    always #5 clk = ~clk;
    always @(posedge clk) tog <= ~tog;
    assign B2H = b2h_force | (b2h_toggle & tog);

    // RAM: data for an address appears one clk later; a CPU-owned cycle returns junk.
    always @(posedge clk) begin
        if (!B2H) begin
            ram_lo <= mem[ram_addr][7:0];
            ram_hi <= mem[ram_addr][15:8];
        end else begin
            ram_lo <= 8'hEE;
            ram_hi <= 8'hEE;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Scoreboard and stall monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (obj_valid && obj_ready) begin
                n_xfer++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $error("FAIL extra_desc: got %0h want none", {obj_pic, obj_attr, obj_x, obj_row});
                end else begin
                    chk("desc", {4'h0, obj_pic, obj_attr, obj_x, obj_row}, {4'h0, exp_q.pop_front()});
                end
            end
            if (b2h_toggle && prev_stall) begin
                n_reissue++;
                chk("reissue_addr", {24'h0, ram_addr}, {24'h0, prev_addr});
            end
            prev_stall = B2H && ((dut.r_state == ST_ADDR1) || (dut.r_state == ST_ADDR0));
            prev_addr  = ram_addr;
        end
    end

    // Driver tasks: inputs change 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_obj(input logic b, input logic [5:0] idx, input logic [7:0] y,
                           input logic [7:0] x, input logic [7:0] pic, input logic [7:0] attr);
        mem[{b, idx, 1'b1}] = {x, y};
        mem[{b, idx, 1'b0}] = {attr, pic};
    endtask

    task automatic line_start(input logic [7:0] vc, input logic bsel);
        hcount    = MO_START_H;
        vcount    = vc;
        BUF1BUF2n = bsel;
        tick();
        hcount    = 9'd0;
    endtask

    task automatic wait_done(input int budget, output int cycles);
        logic seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (line_done) seen = 1'b1;
            else           tick();
        end
        chk("done_timeout", {31'h0, seen}, 32'h1);
        if (seen) tick();
    endtask

    task automatic wait_valid(input int budget);
        logic seen;
        int   n;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (obj_valid) seen = 1'b1;
            else           tick();
        end
        chk("valid_timeout", {31'h0, seen}, 32'h1);
    endtask

    initial begin
        int cyc;
        int x0;

        reset      = 1'b1;
        hcount     = 9'd0;
        vcount     = 8'd0;
        BUF1BUF2n  = 1'b0;
        b2h_force  = 1'b0;
        b2h_toggle = 1'b0;
        obj_ready  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            set_obj(1'b0, 6'(i), 8'h80, 8'(i), 8'(i), 8'(i));
            set_obj(1'b1, 6'(i), 8'h30, 8'(2 * i), 8'(i), 8'h40 | 8'(i));
        end
        set_obj(1'b0, 6'd0, 8'h20, 8'h40, 8'h12, 8'h83);

        // Reset state
        tick(); tick(); tick();
        @(negedge clk);
        chk("rst_addr",      {24'h0, ram_addr}, 32'h0);
        chk("rst_valid",     {31'h0, obj_valid}, 32'h0);
        chk("rst_pic",       {24'h0, obj_pic}, 32'h0);
        chk("rst_attr",      {24'h0, obj_attr}, 32'h0);
        chk("rst_x",         {24'h0, obj_x}, 32'h0);
        chk("rst_row",       {28'h0, obj_row}, 32'h0);
        chk("rst_line_done", {31'h0, line_done}, 32'h0);
        chk("rst_overflow",  {31'h0, overflow}, 32'h0);
        chk("rst_overrun",   {31'h0, overrun}, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Single in-range object, target 0x25 -> row 5; 63 rejects at 2 clks each
        obj_ready = 1'b1;
        exp_q.push_back({8'h12, 8'h83, 8'h40, 4'd5});
        x0 = n_xfer;
        line_start(8'h24, 1'b0);
        wait_done(400, cyc);
        chk("t1_cycles", 32'(cyc), 32'd132);
        chk("t1_xfers",  32'(n_xfer - x0), 32'd1);
        chk("t1_q_left", 32'(exp_q.size()), 32'd0);
        chk("t1_overflow", {31'h0, overflow}, 32'h0);
        chk("t1_overrun",  {31'h0, overrun}, 32'h0);
        @(negedge clk);
        chk("t1_done_pulse", {31'h0, line_done}, 32'h0);
        chk("t1_addr_hold",  {24'h0, ram_addr}, 32'h7F);
        tick();

        // All 64 objects on line: 16 descriptors then overflow
        for (int i = 0; i < 16; i++)
            exp_q.push_back({8'(i), 8'h40 | 8'(i), 8'(2 * i), 4'd1});
        x0 = n_xfer;
        line_start(8'h30, 1'b1);
        wait_done(400, cyc);
        chk("t2_cycles",   32'(cyc), 32'd81);
        chk("t2_xfers",    32'(n_xfer - x0), 32'd16);
        chk("t2_q_left",   32'(exp_q.size()), 32'd0);
        chk("t2_overflow", {31'h0, overflow}, 32'h1);
        chk("t2_overrun",  {31'h0, overrun}, 32'h0);

        // Same scan with the CPU owning the bus every other clk
        for (int i = 0; i < 16; i++)
            exp_q.push_back({8'(i), 8'h40 | 8'(i), 8'(2 * i), 4'd1});
        x0 = n_xfer;
        b2h_toggle = 1'b1;
        line_start(8'h30, 1'b1);
        @(negedge clk);
        chk("t3_overflow_clr", {31'h0, overflow}, 32'h0);
        tick();
        wait_done(1000, cyc);
        b2h_toggle = 1'b0;
        chk("t3_xfers",    32'(n_xfer - x0), 32'd16);
        chk("t3_q_left",   32'(exp_q.size()), 32'd0);
        chk("t3_overflow", {31'h0, overflow}, 32'h1);
        chk("t3_stalls",   {31'h0, (n_reissue > 0)}, 32'h1);

        // Painter stall: descriptor must hold for the whole stall
        obj_ready = 1'b0;
        exp_q.push_back({8'h12, 8'h83, 8'h40, 4'd5});
        x0 = n_xfer;
        line_start(8'h24, 1'b0);
        wait_valid(20);
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            chk("t4_valid", {31'h0, obj_valid}, 32'h1);
            chk("t4_pic",   {24'h0, obj_pic}, 32'h12);
            chk("t4_attr",  {24'h0, obj_attr}, 32'h83);
            chk("t4_x",     {24'h0, obj_x}, 32'h40);
            chk("t4_row",   {28'h0, obj_row}, 32'h5);
        end
        tick();
        obj_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t4_valid_drop", {31'h0, obj_valid}, 32'h0);
        tick();
        wait_done(400, cyc);
        chk("t4_xfers",  32'(n_xfer - x0), 32'd1);
        chk("t4_q_left", 32'(exp_q.size()), 32'd0);

        // Next line start while a descriptor waits: abort, overrun, new buffer
        obj_ready = 1'b0;
        x0 = n_xfer;
        line_start(8'h24, 1'b0);
        wait_valid(20);
        tick();
        hcount    = MO_START_H;
        vcount    = 8'h30;
        BUF1BUF2n = 1'b1;
        @(negedge clk);
        chk("t5_valid_gated", {31'h0, obj_valid}, 32'h0);
        tick();
        hcount = 9'd0;
        @(negedge clk);
        chk("t5_overrun",  {31'h0, overrun}, 32'h1);
        chk("t5_valid",    {31'h0, obj_valid}, 32'h0);
        chk("t5_addr",     {24'h0, ram_addr}, 32'h81);
        chk("t5_overflow", {31'h0, overflow}, 32'h0);
        chk("t5_xfers",    32'(n_xfer - x0), 32'd0);
        tick();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();

        // Vertical wrap: y=0xFA on target 4 -> row 10; y=0x05 rejected
        set_obj(1'b0, 6'd0, 8'hFA, 8'h11, 8'h21, 8'h05);
        set_obj(1'b0, 6'd1, 8'h05, 8'h22, 8'h33, 8'h44);
        obj_ready = 1'b1;
        exp_q.push_back({8'h21, 8'h05, 8'h11, 4'd10});
        x0 = n_xfer;
        line_start(8'h03, 1'b0);
        wait_done(400, cyc);
        chk("t6_cycles", 32'(cyc), 32'd132);
        chk("t6_xfers",  32'(n_xfer - x0), 32'd1);
        chk("t6_q_left", 32'(exp_q.size()), 32'd0);

        // Reset while in READ0
        line_start(8'h30, 1'b1);
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("t7_addr_pre", {24'h0, ram_addr}, 32'h80);
        reset = 1'b1;
        tick();
        @(negedge clk);
        chk("t7_addr",      {24'h0, ram_addr}, 32'h0);
        chk("t7_valid",     {31'h0, obj_valid}, 32'h0);
        chk("t7_pic",       {24'h0, obj_pic}, 32'h0);
        chk("t7_attr",      {24'h0, obj_attr}, 32'h0);
        chk("t7_x",         {24'h0, obj_x}, 32'h0);
        chk("t7_row",       {28'h0, obj_row}, 32'h0);
        chk("t7_line_done", {31'h0, line_done}, 32'h0);
        chk("t7_overflow",  {31'h0, overflow}, 32'h0);
        chk("t7_overrun",   {31'h0, overrun}, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
